// File: rtl/divider_s_18bits_9bits_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : divider_s_18bits_9bits_seq
// Brief    : Iterative radix-2 restoring divider, 18-bit dividend / 9-bit
//            divisor, per-operand signed/unsigned, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module divider_s_18bits_9bits_seq #(
    parameter int N_W = 18,
    parameter int D_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] N,
    input  logic [D_W-1:0] D,
    input  logic           N_sign,
    input  logic           D_sign,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] Q,
    output logic [D_W-1:0] R,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N_W);
    localparam logic [CW-1:0]  c_last  = CW'(N_W - 1);
    localparam logic [N_W-1:0] c_qhalf = {1'b1, {(N_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_nq starts as |N| and is shifted left; quotient bits enter at the LSB.
    logic [N_W-1:0] r_nq;
    logic [D_W:0]   r_pr;
    logic [D_W-1:0] r_dmag;
    logic [D_W-1:0] r_nlow;
    logic [CW-1:0]  r_cnt;
    logic           r_qsign;
    logic           r_rsign;
    logic           r_smode;
    logic           r_dz;

    logic           w_accept;
    logic           w_n_neg;
    logic           w_d_neg;
    logic [N_W-1:0] w_nmag;
    logic [D_W-1:0] w_dmag;
    logic [D_W+1:0] w_trial;
    logic           w_ge;
    logic [D_W:0]   w_pr_next;
    logic [D_W-1:0] w_rmag;

    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;

    assign w_n_neg = N_sign & N[N_W-1];
    assign w_d_neg = D_sign & D[D_W-1];
    assign w_nmag  = w_n_neg ? (~N + 1'b1) : N;
    assign w_dmag  = w_d_neg ? (~D + 1'b1) : D;

    assign w_trial   = {r_pr, r_nq[N_W-1]};
    assign w_ge      = (w_trial >= (D_W+2)'(r_dmag));
    assign w_pr_next = (D_W+1)'(w_ge ? (w_trial - (D_W+2)'(r_dmag)) : w_trial);
    assign w_rmag    = r_pr[D_W-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = CALC;
            CALC: if (r_cnt == c_last) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nq        <= '0;
            r_pr        <= '0;
            r_dmag      <= '0;
            r_nlow      <= '0;
            r_cnt       <= '0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_smode     <= 1'b0;
            r_dz        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_nq    <= w_nmag;
                        r_pr    <= '0;
                        r_dmag  <= w_dmag;
                        r_nlow  <= N[D_W-1:0];
                        r_cnt   <= '0;
                        r_qsign <= w_n_neg ^ w_d_neg;
                        r_rsign <= w_n_neg;
                        r_smode <= N_sign | D_sign;
                        r_dz    <= (D == '0);
                    end
                end
                CALC: begin
                    r_pr  <= w_pr_next;
                    r_nq  <= {r_nq[N_W-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    div_by_zero <= r_dz;
                    if (r_dz) begin
                        Q        <= '1;
                        R        <= r_nlow;
                        overflow <= 1'b0;
                    end else begin
                        Q        <= r_qsign ? (~r_nq + 1'b1) : r_nq;
                        R        <= r_rsign ? (~w_rmag + 1'b1) : w_rmag;
                        // Negative results may reach -2^(N_W-1); positive ones may not.
                        overflow <= r_smode && (r_qsign ? (r_nq > c_qhalf)
                                                        : (r_nq >= c_qhalf));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
